// File: rtl/ioctl_vram_loader_if.sv
// ioctl_vram_loader_if: ioctl, video-read and VRAM port signals of the download loader
interface ioctl_vram_loader_if #(parameter int ADDR_W = 16);
  logic ioctl_download;
  logic ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0] ioctl_dout;
  logic [7:0] ioctl_index;
  logic ioctl_wait;
  logic vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic vid_ack;
  logic [7:0] vid_data;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_we;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic load_done;
  logic overflow;
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, vid_req, vid_addr, ram_dout,
    input ioctl_wait, vid_ack, vid_data, ram_addr, ram_we, ram_din, load_done, overflow
  );
  modport slave (
    input ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, vid_req, vid_addr, ram_dout,
    output ioctl_wait, vid_ack, vid_data, ram_addr, ram_we, ram_din, load_done, overflow
  );
endinterface

// File: rtl/ioctl_vram_loader.sv
// ioctl_vram_loader: queues ioctl download bytes and shares the VRAM port with video reads
module ioctl_vram_loader #(
  parameter int ADDR_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] LOAD_INDEX = 8'h01,
  parameter int STARVE_MAX = 8
) (
  input logic clk_sys,
  input logic reset,
  ioctl_vram_loader_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W+7:0] mem_q [FIFO_DEPTH];
  logic [CW-1:0] wp_q, rp_q;
  logic [CW:0] cnt_q, cnt_d;
  logic pend_q, rd1_q, rd2_q;
  logic [ADDR_W-1:0] pend_addr_q, rd_addr;
  logic [SW-1:0] starve_q;
  logic hit, push, full, push_ok, ne, rd_v, rd_go, pop;
  always_comb begin
    hit = bus.ioctl_index == LOAD_INDEX;
    push = state_q == LOAD && bus.ioctl_wr && hit && (bus.ioctl_addr >> ADDR_W) == '0;
    full = cnt_q == (CW+1)'(FIFO_DEPTH);
    push_ok = push && !full;
    ne = cnt_q != '0;
    rd_v = pend_q || bus.vid_req;
    rd_addr = pend_q ? pend_addr_q : bus.vid_addr;
    // video wins unless it has already starved a non-empty FIFO for STARVE_MAX grants
    rd_go = rd_v && !(starve_q == SW'(STARVE_MAX) && ne);
    pop = !rd_go && ne;
    cnt_d = cnt_q + (CW+1)'(push_ok) - (CW+1)'(pop);
    state_d = state_q == IDLE ? (bus.ioctl_download && hit ? LOAD : IDLE) :
              state_q == LOAD ? (bus.ioctl_download ? LOAD : FLUSH) :
              state_q == FLUSH ? (ne ? FLUSH : DONE) : IDLE;
  end
  always_ff @(posedge clk_sys)
    if (push_ok) mem_q[wp_q] <= {bus.ioctl_addr[ADDR_W-1:0], bus.ioctl_dout};
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      pend_addr_q <= '0;
      rd1_q <= 1'b0;
      rd2_q <= 1'b0;
      starve_q <= '0;
      bus.ioctl_wait <= 1'b0;
      bus.vid_ack <= 1'b0;
      bus.vid_data <= '0;
      bus.ram_addr <= '0;
      bus.ram_we <= 1'b0;
      bus.ram_din <= '0;
      bus.load_done <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (push_ok) wp_q <= wp_q + CW'(1);
      if (pop) rp_q <= rp_q + CW'(1);
      pend_q <= rd_go ? 1'b0 : rd_v;
      if (bus.vid_req && !pend_q) pend_addr_q <= bus.vid_addr;
      rd1_q <= rd_go;
      rd2_q <= rd1_q;
      bus.vid_ack <= rd2_q;
      if (rd2_q) bus.vid_data <= bus.ram_dout;
      bus.ram_we <= pop;
      if (rd_go) bus.ram_addr <= rd_addr;
      else if (pop) {bus.ram_addr, bus.ram_din} <= mem_q[rp_q];
      starve_q <= rd_go && ne ? starve_q + SW'(1) : '0;
      bus.ioctl_wait <= state_d == LOAD && cnt_d >= (CW+1)'(FIFO_DEPTH - 1);
      bus.load_done <= state_q == FLUSH && !ne;
      bus.overflow <= state_q == IDLE && state_d == LOAD ? 1'b0 : bus.overflow | (push && full);
    end
  end
endmodule

// File: tb/tb_ioctl_vram_loader.sv
// tb_ioctl_vram_loader: random downloads and video reads checked against a cycle reference model
module tb_ioctl_vram_loader;
  localparam int DEPTH = 4;
  localparam int SMAX = 8;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  ioctl_vram_loader_if #(.ADDR_W(16)) bus ();
  ioctl_vram_loader dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));
  always #5 clk_sys = ~clk_sys;
  function automatic logic [7:0] h(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  always @(posedge clk_sys) bus.ram_dout <= h(bus.ram_addr);
  // reference model state: 0 idle, 1 load, 2 flush, 3 done
  int mst;
  logic [23:0] q[$];
  bit m_pend, p1_v, p2_v;
  logic [15:0] m_paddr, p1_a, p2_a;
  int m_starve;
  bit e_we, e_ack, e_wait, e_done, e_ovf;
  logic [15:0] e_addr;
  logic [7:0] e_din, e_vdata;
  int vcnt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    bit ne, full, rd;
    logic [15:0] ra;
    if (reset) begin
      mst = 0; q.delete(); m_pend = 0; p1_v = 0; p2_v = 0; m_starve = 0;
      e_we = 0; e_ack = 0; e_wait = 0; e_done = 0; e_ovf = 0;
      e_addr = '0; e_din = '0; e_vdata = '0;
      return;
    end
    ne = q.size() > 0;
    full = q.size() == DEPTH;
    rd = m_pend || bus.vid_req;
    ra = m_pend ? m_paddr : bus.vid_addr;
    e_ack = p2_v;
    if (p2_v) e_vdata = h(p2_a);
    p2_v = p1_v; p2_a = p1_a; p1_v = 0;
    e_we = 0;
    if (rd && !(m_starve == SMAX && ne)) begin
      e_addr = ra; p1_v = 1; p1_a = ra;
      m_starve = ne ? m_starve + 1 : 0;
      m_pend = 0;
    end else begin
      if (!m_pend && bus.vid_req) begin m_pend = 1; m_paddr = bus.vid_addr; end
      if (ne) begin {e_addr, e_din} = q.pop_front(); e_we = 1; end
      m_starve = 0;
    end
    if (mst == 1 && bus.ioctl_wr && bus.ioctl_index == 8'h01 && bus.ioctl_addr < 25'h10000) begin
      if (full) e_ovf = 1;
      else q.push_back({bus.ioctl_addr[15:0], bus.ioctl_dout});
    end
    case (mst)
      0: if (bus.ioctl_download && bus.ioctl_index == 8'h01) begin mst = 1; e_ovf = 0; end
      1: if (!bus.ioctl_download) mst = 2;
      2: if (!ne) mst = 3;
      default: mst = 0;
    endcase
    e_done = mst == 3;
    e_wait = mst == 1 && q.size() >= DEPTH - 1;
  endtask
  task automatic cyc();
    @(posedge clk_sys);
    step();
    #1;
    chk("ram_we", bus.ram_we, e_we);
    chk("ram_addr", bus.ram_addr, e_addr);
    chk("ram_din", bus.ram_din, e_din);
    chk("vid_ack", bus.vid_ack, e_ack);
    chk("vid_data", bus.vid_data, e_vdata);
    chk("ioctl_wait", bus.ioctl_wait, e_wait);
    chk("load_done", bus.load_done, e_done);
    chk("overflow", bus.overflow, e_ovf);
  endtask
  task automatic vid(input int mode);
    bus.vid_addr = 16'($urandom);
    bus.vid_req = mode == 1 ? $urandom_range(0, 3) == 0 :
                  mode == 2 ? 1'b1 :
                  mode == 3 ? (bus.vid_ack || vcnt == 0) : 1'b0;
    vcnt++;
  endtask
  task automatic download(input logic [7:0] idx, input int n, input bit honour, input int vmode, input bit rst_mid);
    int sent = 0;
    int guard = 0;
    bit did_rst = 0;
    vcnt = 0;
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
    while (sent < n && guard < 2000) begin
      guard++;
      bus.ioctl_wr = 1'b0;
      if ($urandom_range(0, 3) != 0 && !(honour && bus.ioctl_wait)) begin
        bus.ioctl_wr = 1'b1;
        bus.ioctl_dout = 8'($urandom);
        bus.ioctl_addr = $urandom_range(0, 15) == 0 ? 25'h10000 + 25'($urandom_range(0, 999)) : 25'($urandom_range(0, 65535));
        sent++;
      end
      vid(vmode);
      reset = rst_mid && !did_rst && sent == n / 2;
      if (reset) did_rst = 1;
      cyc();
      if (reset) chk("rst_ram_we", bus.ram_we, 1'b0);
      reset = 1'b0;
    end
    chk("wr_guard", guard < 2000, 1'b1);
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    repeat (40) begin vid(vmode); cyc(); end
    bus.vid_req = 1'b0;
    repeat (4) cyc();
  endtask
  initial begin
    bus.ioctl_download = 0; bus.ioctl_wr = 0; bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    bus.ioctl_index = '0; bus.vid_req = 0; bus.vid_addr = '0;
    reset = 1'b1;
    repeat (2) cyc();
    chk("rst_state", {bus.ram_we, bus.vid_ack, bus.ioctl_wait, bus.load_done, bus.overflow}, 5'b0);
    reset = 1'b0;
    cyc();
    bus.ioctl_index = 8'h01;
    bus.ioctl_download = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus.ioctl_wr = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = 8'((i + 1) * 8'h11);
      cyc();
      bus.ioctl_wr = 1'b0;
      cyc();
    end
    bus.ioctl_download = 1'b0;
    repeat (8) cyc();
    download(8'h01, 6, 1, 0, 0);
    download(8'h01, 16, 0, 2, 0);
    download(8'h01, 20, 1, 3, 0);
    download(8'h02, 5, 0, 1, 0);
    download(8'h01, 12, 0, 2, 1);
    download(8'h01, 6, 1, 1, 0);
    repeat (12) download($urandom_range(0, 4) == 0 ? 8'h02 : 8'h01, $urandom_range(1, 30),
                         1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
